// File: rtl/mp1000_cart_loader.sv
// MP1000 cartridge loader: writes HPS ioctl download bytes into cartridge ROM,
// records image size and mirror mask, and holds the CPU in reset around a load.
module mp1000_cart_loader #(
  parameter int         ROM_AW      = 13,
  parameter logic [7:0] CART_INDEX  = 8'd1,
  parameter int         HOLD_CYCLES = 16
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              rom_we,
  output logic [ROM_AW-1:0] rom_addr,
  output logic [7:0]        rom_din,
  output logic [ROM_AW:0]   cart_size,
  output logic [ROM_AW-1:0] cart_mask,
  output logic              cart_loaded,
  output logic              overflow,
  output logic              cpu_reset_hold
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_FINISH,
    S_HOLD
  } state_t;

  state_t            state, state_nxt;
  logic              dl_prev;
  logic [7:0]        hold_cnt, hold_cnt_nxt;
  logic              rom_we_nxt;
  logic [ROM_AW-1:0] rom_addr_nxt;
  logic [7:0]        rom_din_nxt;
  logic [ROM_AW:0]   cart_size_nxt;
  logic [ROM_AW-1:0] cart_mask_nxt;
  logic              cart_loaded_nxt;
  logic              overflow_nxt;
  logic              cpu_reset_hold_nxt;

  logic              start;
  logic              in_range;
  logic [ROM_AW:0]   wr_size;
  logic [ROM_AW:0]   size_m1;

  // Every bit at or below the highest set bit becomes set.
  function automatic logic [ROM_AW-1:0] smear(input logic [ROM_AW-1:0] v);
    logic [ROM_AW-1:0] m;
    m = v;
    for (int i = ROM_AW - 2; i >= 0; i--) m[i] = m[i] | m[i+1];
    return m;
  endfunction

  assign start    = ioctl_download && !dl_prev && (ioctl_index == CART_INDEX);
  assign in_range = (ioctl_addr[24:ROM_AW] == '0);
  assign wr_size  = {1'b0, ioctl_addr[ROM_AW-1:0]} + (ROM_AW+1)'(1);
  assign size_m1  = cart_size - (ROM_AW+1)'(1);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned; a missing default here would infer a latch.
    state_nxt          = state;
    hold_cnt_nxt       = hold_cnt;
    rom_we_nxt         = 1'b0;
    rom_addr_nxt       = rom_addr;
    rom_din_nxt        = rom_din;
    cart_size_nxt      = cart_size;
    cart_mask_nxt      = cart_mask;
    cart_loaded_nxt    = cart_loaded;
    overflow_nxt       = overflow;
    cpu_reset_hold_nxt = cpu_reset_hold;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt          = S_LOAD;
          cart_size_nxt      = '0;
          overflow_nxt       = 1'b0;
          cart_loaded_nxt    = 1'b0;
          cpu_reset_hold_nxt = 1'b1;
        end
      end
      S_LOAD: begin
        // A strobe coinciding with the falling download edge is still taken.
        if (ioctl_wr) begin
          if (in_range) begin
            rom_we_nxt   = 1'b1;
            rom_addr_nxt = ioctl_addr[ROM_AW-1:0];
            rom_din_nxt  = ioctl_dout;
            if (wr_size > cart_size) cart_size_nxt = wr_size;
          end else begin
            overflow_nxt = 1'b1;
          end
        end
        if (!ioctl_download) state_nxt = S_FINISH;
      end
      S_FINISH: begin
        cart_mask_nxt = (cart_size == '0) ? '1 : smear(size_m1[ROM_AW-1:0]);
        hold_cnt_nxt  = 8'(HOLD_CYCLES - 1);
        state_nxt     = S_HOLD;
      end
      S_HOLD: begin
        // Counter starts at HOLD_CYCLES-1 so the hold spans exactly HOLD_CYCLES edges.
        if (hold_cnt == '0) begin
          state_nxt          = S_IDLE;
          cpu_reset_hold_nxt = 1'b0;
          cart_loaded_nxt    = (cart_size != '0);
        end else begin
          hold_cnt_nxt = hold_cnt - 8'd1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!reset_n) begin
      state          <= S_IDLE;
      // Seeded high so a download already active when reset lifts is not a start.
      dl_prev        <= 1'b1;
      hold_cnt       <= '0;
      rom_we         <= 1'b0;
      rom_addr       <= '0;
      rom_din        <= '0;
      cart_size      <= '0;
      cart_mask      <= '1;
      cart_loaded    <= 1'b0;
      overflow       <= 1'b0;
      cpu_reset_hold <= 1'b0;
    end else begin
      state          <= state_nxt;
      dl_prev        <= ioctl_download;
      hold_cnt       <= hold_cnt_nxt;
      rom_we         <= rom_we_nxt;
      rom_addr       <= rom_addr_nxt;
      rom_din        <= rom_din_nxt;
      cart_size      <= cart_size_nxt;
      cart_mask      <= cart_mask_nxt;
      cart_loaded    <= cart_loaded_nxt;
      overflow       <= overflow_nxt;
      cpu_reset_hold <= cpu_reset_hold_nxt;
    end
  end

endmodule

// File: tb/tb_mp1000_cart_loader.sv
// Self-checking bench for mp1000_cart_loader: directed load scenarios with
// random data/addresses, compared against a behavioural model of the loader.
module tb_mp1000_cart_loader;

  localparam int ROM_AW = 13;
  localparam int CAP    = 1 << ROM_AW;
  localparam int HOLD   = 16;

  logic              clk_sys = 1'b0;
  logic              reset_n;
  logic              ioctl_download;
  logic [7:0]        ioctl_index;
  logic              ioctl_wr;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic              rom_we;
  logic [ROM_AW-1:0] rom_addr;
  logic [7:0]        rom_din;
  logic [ROM_AW:0]   cart_size;
  logic [ROM_AW-1:0] cart_mask;
  logic              cart_loaded;
  logic              overflow;
  logic              cpu_reset_hold;

  always #5 clk_sys = ~clk_sys;

  mp1000_cart_loader #(
    .ROM_AW     (ROM_AW),
    .CART_INDEX (8'd1),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clk_sys       (clk_sys),
    .reset_n       (reset_n),
    .ioctl_download(ioctl_download),
    .ioctl_index   (ioctl_index),
    .ioctl_wr      (ioctl_wr),
    .ioctl_addr    (ioctl_addr),
    .ioctl_dout    (ioctl_dout),
    .rom_we        (rom_we),
    .rom_addr      (rom_addr),
    .rom_din       (rom_din),
    .cart_size     (cart_size),
    .cart_mask     (cart_mask),
    .cart_loaded   (cart_loaded),
    .overflow      (overflow),
    .cpu_reset_hold(cpu_reset_hold)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  always @(posedge clk_sys) cyc <= cyc + 1;

  typedef struct {
    int due;
    int addr;
    int data;
  } wr_t;

  wr_t exp_q[$];
  int  st_addr[$];
  int  st_data[$];
  int  st_gap[$];

  int m_size   = 0;
  int m_mask   = CAP - 1;
  int m_over   = 0;
  int m_loaded = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check_status(input string tag);
    check({tag, ".size"},   32'(cart_size),   32'(m_size));
    check({tag, ".mask"},   32'(cart_mask),   32'(m_mask));
    check({tag, ".ovf"},    32'(overflow),    32'(m_over));
    check({tag, ".loaded"}, 32'(cart_loaded), 32'(m_loaded));
  endtask

  task automatic add(input int a, input int d, input int g);
    st_addr.push_back(a);
    st_data.push_back(d);
    st_gap.push_back(g);
  endtask

  // Every ROM write must appear exactly one cycle after its strobe.
  always @(negedge clk_sys) begin
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      check("rom_we", 32'(rom_we), 32'd1);
      check("rom_addr", 32'(rom_addr), 32'(exp_q[0].addr));
      check("rom_din", 32'(rom_din), 32'(exp_q[0].data));
      void'(exp_q.pop_front());
    end else begin
      check("rom_we_idle", 32'(rom_we), 32'd0);
    end
  end

  task automatic run_load(input logic [7:0] idx, input bit fall_with_wr);
    bit accept;
    int n;
    int sz;
    int ov;
    int p;
    accept = (idx == 8'd1);
    n      = st_addr.size();
    sz     = 0;
    ov     = 0;

    ioctl_index    = idx;
    ioctl_download = 1'b1;
    ioctl_wr       = 1'b0;
    tick();
    @(negedge clk_sys);
    if (accept) begin
      check("start.hold", 32'(cpu_reset_hold), 32'd1);
      check("start.size", 32'(cart_size), 32'd0);
      check("start.ovf", 32'(overflow), 32'd0);
      check("start.loaded", 32'(cart_loaded), 32'd0);
    end else begin
      check("ign.hold", 32'(cpu_reset_hold), 32'd0);
      check_status("ign.start");
    end

    for (int i = 0; i < n; i++) begin
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'(st_addr[i]);
      ioctl_dout = 8'(st_data[i]);
      if (accept) begin
        if (st_addr[i] < CAP) begin
          exp_q.push_back('{due: cyc + 1, addr: st_addr[i], data: st_data[i]});
          if (st_addr[i] + 1 > sz) sz = st_addr[i] + 1;
        end else begin
          ov = 1;
        end
      end
      if (fall_with_wr && i == n - 1) ioctl_download = 1'b0;
      tick();
      ioctl_wr = 1'b0;
      if (!accept) check("ign.hold_run", 32'(cpu_reset_hold), 32'd0);
      if (!(fall_with_wr && i == n - 1)) repeat (st_gap[i]) tick();
    end

    if (!(fall_with_wr && n > 0)) begin
      ioctl_download = 1'b0;
      tick();
    end

    if (accept) begin
      m_size = sz;
      m_over = ov;
      if (sz == 0) begin
        m_mask = CAP - 1;
      end else begin
        p = 1;
        while (p < sz) p = p * 2;
        m_mask = p - 1;
      end
      m_loaded = (sz != 0) ? 1 : 0;
      for (int c = 0; c < HOLD + 1; c++) begin
        @(negedge clk_sys);
        check("hold.high", 32'(cpu_reset_hold), 32'd1);
        check("hold.loaded_low", 32'(cart_loaded), 32'd0);
      end
      @(negedge clk_sys);
      check("hold.fall", 32'(cpu_reset_hold), 32'd0);
      check_status("done");
    end else begin
      repeat (4) tick();
      check("ign.hold_end", 32'(cpu_reset_hold), 32'd0);
      check_status("ign.end");
    end
    check("q_drained", 32'(exp_q.size()), 32'd0);
    st_addr.delete();
    st_data.delete();
    st_gap.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int lim;
    int n;

    // Power-on reset with a cartridge download already active: must be ignored.
    reset_n        = 1'b0;
    ioctl_download = 1'b1;
    ioctl_index    = 8'd1;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    repeat (3) tick();
    reset_n = 1'b1;
    @(negedge clk_sys);
    check("rst.rom_addr", 32'(rom_addr), 32'd0);
    check("rst.rom_din", 32'(rom_din), 32'd0);
    check("rst.hold", 32'(cpu_reset_hold), 32'd0);
    check_status("rst");
    repeat (5) tick();
    check("rst.dl_high_ignored", 32'(cpu_reset_hold), 32'd0);
    ioctl_download = 1'b0;
    repeat (3) tick();

    // 4096 bytes, data = addr[7:0], one strobe every 4 cycles.
    for (int a = 0; a < 4096; a++) add(a, a & 8'hFF, 3);
    run_load(8'd1, 1'b0);

    // 3000 bytes back to back; last strobe shares the cycle of the falling download.
    for (int a = 0; a < 3000; a++) add(a, int'($urandom_range(0, 255)), 0);
    run_load(8'd1, 1'b1);

    // 9000 bytes: everything at or above capacity must be dropped and flagged.
    for (int a = 0; a < 9000; a++) add(a, int'($urandom_range(0, 255)), int'($urandom_range(0, 1)));
    run_load(8'd1, 1'b0);

    // Foreign index: no writes, no CPU hold, status untouched.
    for (int a = 0; a < 100; a++) add(a, int'($urandom_range(0, 255)), 0);
    run_load(8'd0, 1'b0);

    // Empty download.
    run_load(8'd1, 1'b0);

    // Reset in the middle of a load at byte 500.
    ioctl_index    = 8'd1;
    ioctl_download = 1'b1;
    tick();
    for (int a = 0; a < 500; a++) begin
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'(a);
      ioctl_dout = 8'($urandom_range(0, 255));
      exp_q.push_back('{due: cyc + 1, addr: a, data: int'(ioctl_dout)});
      tick();
      ioctl_wr = 1'b0;
      tick();
    end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    m_size   = 0;
    m_mask   = CAP - 1;
    m_over   = 0;
    m_loaded = 0;
    @(negedge clk_sys);
    check("midrst.rom_addr", 32'(rom_addr), 32'd0);
    check("midrst.rom_din", 32'(rom_din), 32'd0);
    check("midrst.hold", 32'(cpu_reset_hold), 32'd0);
    check_status("midrst");
    for (int a = 500; a < 600; a++) begin
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'(a);
      ioctl_dout = 8'($urandom_range(0, 255));
      tick();
      ioctl_wr = 1'b0;
      check("midrst.hold_run", 32'(cpu_reset_hold), 32'd0);
    end
    ioctl_download = 1'b0;
    repeat (20) tick();
    check("midrst.hold_end", 32'(cpu_reset_hold), 32'd0);
    check_status("midrst.end");

    // Random scattered loads, some reaching beyond capacity.
    for (int r = 0; r < 4; r++) begin
      lim = int'($urandom_range(0, 9500));
      n   = int'($urandom_range(1, 200));
      for (int k = 0; k < n; k++)
        add(int'($urandom_range(0, lim)), int'($urandom_range(0, 255)), int'($urandom_range(0, 2)));
      run_load(8'd1, 1'($urandom_range(0, 1)));
      repeat (3) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
